// File: rtl/logip_pkg.sv
// Shared logIP definitions: transmit serializer state encoding and byte count.
package logip_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_ser_state_t;

  localparam int LOGIP_TX_BYTES = 4;

endpackage

// File: rtl/logip_tx_serializer.sv
// Serializes 32-bit logIP result words LSB byte first onto a valid/ready byte stream.
// Optional per-byte skip mask (grp_dis_i) is enabled by defining LOGIP_TX_GRPMASK_EN.
module logip_tx_serializer
  import logip_pkg::*;
#(
  parameter int WORD_W = 8 * LOGIP_TX_BYTES,
  localparam int BYTES = WORD_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              stb_i,
  output logic              rdy_o,
  output logic [7:0]        byte_o,
  output logic              byte_vld_o,
  input  logic              byte_rdy_i,
`ifdef LOGIP_TX_GRPMASK_EN
  input  logic [BYTES-1:0]  grp_dis_i,
`endif
  output logic              ovf_o
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  tx_ser_state_t     state;
  logic [WORD_W-1:0] hold;
  logic [BYTES-1:0]  dis_q;
  logic [BYTES-1:0]  dis_in;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    first_sel;
  logic [IDX_W:0]    next_sel;

`ifdef LOGIP_TX_GRPMASK_EN
  assign dis_in = grp_dis_i;
`else
  assign dis_in = '0;
`endif

  // Lowest enabled byte at or above start; MSB of the result flags that one exists.
  function automatic logic [IDX_W:0] next_en(input logic [BYTES-1:0] dis, input int start);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (i >= start && !dis[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    first_sel = next_en(dis_in, 0);
    next_sel  = next_en(dis_q, int'(idx) + 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rdy_o      <= 1'b1;
      byte_vld_o <= 1'b0;
      byte_o     <= '0;
      ovf_o      <= 1'b0;
      hold       <= '0;
      dis_q      <= '0;
      idx        <= '0;
    end else begin
      if (stb_i && !rdy_o) ovf_o <= 1'b1;
      case (state)
        IDLE: begin
          if (stb_i) begin
            hold       <= word_i;
            dis_q      <= dis_in;
            idx        <= first_sel[IDX_W-1:0];
            byte_o     <= word_i[8*first_sel[IDX_W-1:0] +: 8];
            // A fully masked word still spends one cycle in SEND with nothing valid.
            byte_vld_o <= first_sel[IDX_W];
            rdy_o      <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (!byte_vld_o) begin
            state <= IDLE;
            rdy_o <= 1'b1;
          end else if (byte_rdy_i) begin
            if (next_sel[IDX_W]) begin
              idx    <= next_sel[IDX_W-1:0];
              byte_o <= hold[8*next_sel[IDX_W-1:0] +: 8];
            end else begin
              state      <= IDLE;
              rdy_o      <= 1'b1;
              byte_vld_o <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          rdy_o      <= 1'b1;
          byte_vld_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logip_tx_serializer.sv
// Directed self-checking bench for logip_tx_serializer; mask tests need LOGIP_TX_GRPMASK_EN.
module tb_logip_tx_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] word_i = '0;
  logic        stb_i = 1'b0;
  logic        rdy_o;
  logic [7:0]  byte_o;
  logic        byte_vld_o;
  logic        byte_rdy_i = 1'b1;
  logic        ovf_o;
`ifdef LOGIP_TX_GRPMASK_EN
  logic [3:0]  grp_dis_i = '0;
`endif

  int checks = 0;
  int errors = 0;

  logip_tx_serializer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .word_i     (word_i),
    .stb_i      (stb_i),
    .rdy_o      (rdy_o),
    .byte_o     (byte_o),
    .byte_vld_o (byte_vld_o),
    .byte_rdy_i (byte_rdy_i),
`ifdef LOGIP_TX_GRPMASK_EN
    .grp_dis_i  (grp_dis_i),
`endif
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled on the falling edge; one call spans one rising edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_rdy"}, 32'(rdy_o), 32'd1);
    check_output({tag, "_vld"}, 32'(byte_vld_o), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [31:0] w);
    word_i = w;
    stb_i  = 1'b1;
    step();
    stb_i  = 1'b0;
  endtask

  logic [31:0] word_a;
  int nb, nw, cyc;
  int strobe_cyc [3];

  initial begin
    word_a = 32'hDDCCBBAA;
    step();
    step();
    rst_i = 1'b0;
    check_output("reset_rdy", 32'(rdy_o), 32'd1);
    check_output("reset_vld", 32'(byte_vld_o), 32'd0);
    check_output("reset_byte", 32'(byte_o), 32'd0);
    check_output("reset_ovf", 32'(ovf_o), 32'd0);

    $display("[TB] single word");
    apply_stimulus(word_a);
    for (int i = 0; i < 4; i++) begin
      check_output("single_vld", 32'(byte_vld_o), 32'd1);
      check_output("single_byte", 32'(byte_o), 32'(word_a[8*i +: 8]));
      check_output("single_rdy", 32'(rdy_o), 32'd0);
      step();
    end
    check_idle("single_end");

    $display("[TB] backpressure");
    apply_stimulus(word_a);
    check_output("bp_b0", 32'(byte_o), 32'hAA);
    step();
    byte_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_output("bp_hold_byte", 32'(byte_o), 32'hBB);
      check_output("bp_hold_vld", 32'(byte_vld_o), 32'd1);
      if (i < 3) step();
    end
    byte_rdy_i = 1'b1;
    step();
    check_output("bp_b2", 32'(byte_o), 32'hCC);
    step();
    check_output("bp_b3", 32'(byte_o), 32'hDD);
    step();
    check_idle("bp_end");

    $display("[TB] overflow");
    apply_stimulus(word_a);
    check_output("ovf_b0", 32'(byte_o), 32'hAA);
    check_output("ovf_pre", 32'(ovf_o), 32'd0);
    apply_stimulus(32'h11223344);
    check_output("ovf_set", 32'(ovf_o), 32'd1);
    check_output("ovf_b1", 32'(byte_o), 32'hBB);
    step();
    check_output("ovf_b2", 32'(byte_o), 32'hCC);
    step();
    check_output("ovf_b3", 32'(byte_o), 32'hDD);
    step();
    check_idle("ovf_end");
    check_output("ovf_sticky", 32'(ovf_o), 32'd1);

    $display("[TB] mid-word reset");
    apply_stimulus(word_a);
    step();
    check_output("mid_b1", 32'(byte_o), 32'hBB);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_idle("mid_rst");
    check_output("mid_ovf", 32'(ovf_o), 32'd0);
    check_output("mid_byte", 32'(byte_o), 32'd0);
    step();
    step();
    check_idle("mid_quiet");

    $display("[TB] back-to-back");
    nb = 0;
    nw = 0;
    for (cyc = 0; cyc < 40 && nb < 12; cyc++) begin
      if (byte_vld_o) begin
        check_output("b2b_byte", 32'(byte_o), 32'(nb));
        nb++;
      end
      if (rdy_o && nw < 3) begin
        stb_i  = 1'b1;
        word_i = {8'(4*nw+3), 8'(4*nw+2), 8'(4*nw+1), 8'(4*nw)};
        strobe_cyc[nw] = cyc;
        nw++;
      end else begin
        stb_i = 1'b0;
      end
      step();
    end
    stb_i = 1'b0;
    check_output("b2b_count", 32'(nb), 32'd12);
    check_output("b2b_rate1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd5);
    check_output("b2b_rate2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd5);
    check_idle("b2b_end");
    check_output("b2b_ovf", 32'(ovf_o), 32'd0);

`ifdef LOGIP_TX_GRPMASK_EN
    $display("[TB] group mask");
    grp_dis_i = 4'b1010;
    apply_stimulus(word_a);
    grp_dis_i = 4'b0000;
    check_output("mask_b0", 32'(byte_o), 32'hAA);
    check_output("mask_v0", 32'(byte_vld_o), 32'd1);
    step();
    check_output("mask_b2", 32'(byte_o), 32'hCC);
    check_output("mask_v2", 32'(byte_vld_o), 32'd1);
    step();
    check_idle("mask_end");

    grp_dis_i = 4'b1111;
    apply_stimulus(word_a);
    grp_dis_i = 4'b0000;
    check_output("all_rdy", 32'(rdy_o), 32'd0);
    check_output("all_vld", 32'(byte_vld_o), 32'd0);
    step();
    check_idle("all_end");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
